// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with an Avalon-MM slave. The channels share one prescaler and one period counter.
// Configuration is double-buffered: shadows are committed to the active copies while idle, or at a period wrap.
module pwm_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int PRESC_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              address,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_CHANNELS-1:0] pwm_out
);

    localparam logic [4:0] A_CTRL    = 5'd0;
    localparam logic [4:0] A_PERIOD  = 5'd1;
    localparam logic [4:0] A_PRESC   = 5'd2;
    localparam logic [4:0] A_STATUS  = 5'd3;
    localparam logic [4:0] A_COUNTER = 5'd4;
    localparam logic [4:0] A_DUTY0   = 5'd8;
    localparam logic [4:0] A_POL     = 5'd24;
    localparam logic [4:0] A_CHEN    = 5'd25;

    logic                    en;
    logic                    en_nxt;
    logic                    wrap_flag;
    logic                    tick;
    logic                    wrap;
    logic                    load_act;
    logic [CNT_WIDTH-1:0]    period_sh;
    logic [CNT_WIDTH-1:0]    period_act;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [PRESC_WIDTH-1:0]  presc_sh;
    logic [PRESC_WIDTH-1:0]  presc_act;
    logic [PRESC_WIDTH-1:0]  pc;
    logic [CNT_WIDTH-1:0]    duty_sh  [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    duty_act [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pol_sh;
    logic [NUM_CHANNELS-1:0] pol_act;
    logic [NUM_CHANNELS-1:0] chen_sh;
    logic [NUM_CHANNELS-1:0] chen_act;
    logic [NUM_CHANNELS-1:0] chan_lvl;
    logic [31:0]             rd_mux;
    logic                    unused_wd;

    assign unused_wd = ^writedata;

    // The next EN value lets a disable force pc/cnt/pwm_out idle on the same edge.
    assign en_nxt   = (write && address == A_CTRL) ? writedata[0] : en;
    assign tick     = en && (pc == presc_act);
    assign wrap     = tick && (cnt == period_act);
    assign load_act = !en || wrap;

    always_comb begin
        chan_lvl = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            chan_lvl[i] = chen_act[i] ? ((cnt < duty_act[i]) ^ pol_act[i]) : pol_act[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            A_CTRL:    rd_mux[0] = en;
            A_PERIOD:  rd_mux[CNT_WIDTH-1:0] = period_sh;
            A_PRESC:   rd_mux[PRESC_WIDTH-1:0] = presc_sh;
            A_STATUS:  rd_mux[1:0] = {wrap_flag, en};
            A_COUNTER: rd_mux[CNT_WIDTH-1:0] = cnt;
            A_POL:     rd_mux[NUM_CHANNELS-1:0] = pol_sh;
            A_CHEN:    rd_mux[NUM_CHANNELS-1:0] = chen_sh;
            default:   rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (address == A_DUTY0 + 5'(i)) begin
                rd_mux = '0;
                rd_mux[CNT_WIDTH-1:0] = duty_sh[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en         <= 1'b0;
            wrap_flag  <= 1'b0;
            period_sh  <= '0;
            period_act <= '0;
            presc_sh   <= '0;
            presc_act  <= '0;
            pol_sh     <= '0;
            pol_act    <= '0;
            chen_sh    <= '0;
            chen_act   <= '0;
            pc         <= '0;
            cnt        <= '0;
            pwm_out    <= '0;
            readdata   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            en <= en_nxt;

            if (write) begin
                case (address)
                    A_PERIOD: period_sh <= writedata[CNT_WIDTH-1:0];
                    A_PRESC:  presc_sh  <= writedata[PRESC_WIDTH-1:0];
                    A_POL:    pol_sh    <= writedata[NUM_CHANNELS-1:0];
                    A_CHEN:   chen_sh   <= writedata[NUM_CHANNELS-1:0];
                    default:  ;
                endcase
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (address == A_DUTY0 + 5'(i)) begin
                        duty_sh[i] <= writedata[CNT_WIDTH-1:0];
                    end
                end
            end

            if (load_act) begin
                period_act <= period_sh;
                presc_act  <= presc_sh;
                pol_act    <= pol_sh;
                chen_act   <= chen_sh;
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    duty_act[i] <= duty_sh[i];
                end
            end

            if (!en_nxt || tick) begin
                pc <= '0;
            end else if (en) begin
                pc <= pc + PRESC_WIDTH'(1);
            end

            if (!en_nxt) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);
            end

            // A wrap wins over a simultaneous write-1-clear.
            if (wrap) begin
                wrap_flag <= 1'b1;
            end else if (write && address == A_STATUS && writedata[1]) begin
                wrap_flag <= 1'b0;
            end

            pwm_out <= (en && en_nxt) ? chan_lvl : pol_act;

            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator with an Avalon-MM slave interface. It is the parametrised successor of the single-output `pwm` component used in the NIOS-only SoC. It provides NUM_CHANNELS outputs that share one period counter and prescaler, with per-channel duty, polarity and enable. All configuration is double-buffered and committed only at a period boundary, so outputs never glitch mid-period.

## Interface
- NUM_CHANNELS, 4, number of PWM outputs, legal range 1..16
- CNT_WIDTH, 16, width of the period counter and the duty registers, legal range 8..32
- PRESC_WIDTH, 8, width of the clock prescaler, legal range 1..16
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  5  word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  read data; fixed read latency of 1; no waitrequest
- pwm_out  out  NUM_CHANNELS  PWM conduit outputs

## Operation
- Register map (word addresses). Written values are truncated to field width. Readback is zero-extended.
  - 0 CTRL: bit0 EN.
  - 1 PERIOD, CNT_WIDTH bits.
  - 2 PRESCALE, PRESC_WIDTH bits.
  - 3 STATUS: bit0 EN (read-only); bit1 WRAP, a sticky flag cleared by writing 1 to bit1.
  - 4 COUNTER, read-only.
  - 8+i DUTY[i], CNT_WIDTH bits, for i < NUM_CHANNELS.
  - 24 POL mask.
  - 25 CHEN mask.
  - Any other address, or a channel address ≥ NUM_CHANNELS: reads return 0 and writes are ignored.
- Shadow and active copies:
  - PERIOD, PRESCALE, DUTY, POL and CHEN writes go to shadow registers.
  - Active copies load from the shadows while EN=0, every cycle.
  - While EN=1, active copies load only on a wrap cycle.
  - CTRL takes effect directly.
- Prescaler `pc`:
  - When EN=0, `pc` holds 0.
  - When EN=1, tick = (pc == PRESCALE_act).
  - On a tick, pc←0; otherwise pc←pc+1.
- Counter `cnt`:
  - When EN=0, `cnt` holds 0.
  - On a tick: if cnt == PERIOD_act, this is a wrap cycle and cnt←0; otherwise cnt←cnt+1.
  - The full period is (PERIOD+1)·(PRESCALE+1) clocks.
- Channel output:
  - raw[i] = (cnt < DUTY_act[i]).
  - pwm_out[i] = CHEN_act[i] ? raw[i] ^ POL_act[i] : POL_act[i].
  - When EN=0, pwm_out[i] = POL_act[i], the idle level.
- Duty boundaries:
  - DUTY=0 gives a constant inactive level.
  - DUTY > PERIOD gives a constant active level, i.e. 100%.
  - PERIOD=0: cnt stays 0, so DUTY≥1 is always active.
- WRAP is set on every wrap cycle. If a set and a write-1-clear happen in the same cycle, the set wins.
- Reset:
  - Clears every shadow, every active copy, CTRL, WRAP, pc, cnt and readdata.
  - pwm_out resets to all 0.
  - A reset mid-period aborts the period immediately.

## Timing
- A write at cycle t updates its register at the t+1 edge.
- EN written 1 at cycle t:
  - pc starts counting at t+1.
  - The active copies seen at t+1 are the shadows loaded while EN was 0.
- EN written 0 at cycle t: pc, cnt and pwm_out reach their idle values at t+1, with pwm_out registered.
- pwm_out is registered. It reflects the cnt and active values of the previous cycle, giving one cycle of output latency.
- Shadow writes made while EN=1 take effect on the first wrap after the write. A write in the same cycle as a wrap takes effect at the next wrap, not the current one.
- readdata is valid in the cycle after read is asserted. It holds its value until the next read.
- A simultaneous read and write to the same address returns the old value.

## Test plan
- **Reset:** assert reset for 2 cycles mid-operation → pwm_out=0, readdata=0, COUNTER reads 0, STATUS reads 0.
- **25% duty:** PERIOD=3, PRESCALE=0, DUTY[0]=1, CHEN=1, POL=0, EN=1 → pwm_out[0] repeats high 1 / low 3 cycles; WRAP sets after 4 cycles; clearing WRAP by write-1 reads back 0.
- **Prescaled and inverted:** PERIOD=9, PRESCALE=4, DUTY[1]=5, POL=2, CHEN=2 → pwm_out[1] is low for 25 clocks then high for 25 clocks, period 50; disabled channels sit at their POL level.
- **Double buffering:** while running, write DUTY[0] from 1 to 3 mid-period → the current period keeps 1 high count; the next period shows 3; no output glitch at the write.
- **Duty boundaries:** with PERIOD=7, DUTY=0 → constant low; DUTY=8 and DUTY=200 → constant high; PERIOD=0 with DUTY=1 → constant high.
- **Register edge cases:** write 0xFFFFFFFF to PERIOD with CNT_WIDTH=16 → reads back 0xFFFF; reads of address 30 and of a channel address ≥ NUM_CHANNELS return 0; writing EN=0 mid-period drives outputs to POL on the next cycle and COUNTER to 0.
